// File: rtl/axi4_resp_pkg.sv
// Shared response encodings, FSM state types and sizing helpers for the AXI4 memory responder.
package axi4_resp_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_DATA = 2'd1,
        W_RESP = 2'd2
    } wr_state_t;

    typedef enum logic {
        R_IDLE = 1'b0,
        R_DATA = 1'b1
    } rd_state_t;

    // Bytes carried by one full-width beat.
    function automatic int unsigned beat_bytes(input int unsigned dw);
        return dw / 8;
    endfunction

    // Width of a word index into a memory of the given depth (at least one bit).
    function automatic int unsigned idx_width(input int unsigned depth);
        return (depth <= 1) ? 1 : $clog2(depth);
    endfunction

endpackage

// File: rtl/axi4_resp_bytemem.sv
// Word-organised storage with a byte-enabled synchronous write port and a combinational read port.
module axi4_resp_bytemem
    import axi4_resp_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 256,
    parameter int unsigned DEPTH      = 1024,
    localparam int unsigned BYTES     = beat_bytes(DATA_WIDTH),
    localparam int unsigned IDXW      = idx_width(DEPTH)
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [IDXW-1:0]       waddr,
    input  logic [BYTES-1:0]      wstrb,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [IDXW-1:0]       raddr,
    output logic [DATA_WIDTH-1:0] rdata_c
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // Byte-lane write; contents are intentionally never reset.
    always_ff @(posedge clk) begin
        if (we) begin
            for (int b = 0; b < int'(BYTES); b++) begin
                if (wstrb[b]) begin
                    mem[waddr][b*8 +: 8] <= wdata[b*8 +: 8];
                end
            end
        end
    end

    assign rdata_c = mem[raddr];

endmodule

// File: rtl/axi4_hbm_mem_responder.sv
// AXI4 subordinate answering INCR full-width bursts from an internal memory window.
module axi4_hbm_mem_responder
    import axi4_resp_pkg::*;
#(
    parameter int unsigned DATA_WIDTH          = 256,
    parameter int unsigned ADDR_WIDTH          = 64,
    parameter int unsigned ID_WIDTH            = 7,
    parameter int unsigned DEPTH               = 1024,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR = '0,
    localparam int unsigned BYTES              = beat_bytes(DATA_WIDTH)
) (
    input  logic                  clk_in_clk,
    input  logic                  reset_n_in_reset_n,
    input  logic [ID_WIDTH-1:0]   awid,
    input  logic [ADDR_WIDTH-1:0] awaddr,
    input  logic [7:0]            awlen,
    input  logic                  awvalid,
    output logic                  awready,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [BYTES-1:0]      wstrb,
    input  logic                  wlast,
    input  logic                  wvalid,
    output logic                  wready,
    output logic [ID_WIDTH-1:0]   bid,
    output logic [1:0]            bresp,
    output logic                  bvalid,
    input  logic                  bready,
    input  logic [ID_WIDTH-1:0]   arid,
    input  logic [ADDR_WIDTH-1:0] araddr,
    input  logic [7:0]            arlen,
    input  logic                  arvalid,
    output logic                  arready,
    output logic [ID_WIDTH-1:0]   rid,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic [1:0]            rresp,
    output logic                  rlast,
    output logic                  rvalid,
    input  logic                  rready
);

    localparam int unsigned OFFW = $clog2(BYTES);
    localparam int unsigned IDXW = idx_width(DEPTH);

    // Beat number relative to the window base; addresses below the base wrap to huge values.
    function automatic logic [ADDR_WIDTH-1:0] beat_off(input logic [ADDR_WIDTH-1:0] a);
        return (a - BASE_ADDR) >> OFFW;
    endfunction

    function automatic logic in_range(input logic [ADDR_WIDTH-1:0] a);
        return beat_off(a) < ADDR_WIDTH'(DEPTH);
    endfunction

    function automatic logic [IDXW-1:0] beat_idx(input logic [ADDR_WIDTH-1:0] a);
        return IDXW'(beat_off(a));
    endfunction

    wr_state_t             wstate;
    logic [ADDR_WIDTH-1:0] waddr_q;
    logic [7:0]            wcnt_q;
    logic [7:0]            wlen_q;
    logic                  werr_q;

    rd_state_t             rstate;
    logic [ADDR_WIDTH-1:0] raddr_q;
    logic [7:0]            rcnt_q;
    logic [7:0]            rlen_q;

    logic                  w_hs_c;
    logic                  w_final_c;
    logic                  w_in_range_c;
    logic                  w_beat_err_c;
    logic                  mem_we_c;
    logic [ADDR_WIDTH-1:0] rd_addr_c;
    logic                  rd_in_range_c;
    logic [DATA_WIDTH-1:0] mem_rdata_c;
    logic [IDXW-1:0]       mem_waddr_c;
    logic [IDXW-1:0]       mem_raddr_c;

    // Per-beat write qualification: out-of-range beats are dropped, wlast must line up with the count.
    always_comb begin
        w_hs_c       = wvalid && wready;
        w_final_c    = (wcnt_q == wlen_q);
        w_in_range_c = in_range(waddr_q);
        w_beat_err_c = !w_in_range_c || (wlast != w_final_c);
        mem_we_c     = w_hs_c && w_in_range_c;
        mem_waddr_c  = beat_idx(waddr_q);
    end

    // Read port address: the AR start address while idle, otherwise the beat after the current one.
    always_comb begin
        rd_addr_c     = (rstate == R_IDLE) ? araddr : (raddr_q + ADDR_WIDTH'(BYTES));
        rd_in_range_c = in_range(rd_addr_c);
        mem_raddr_c   = beat_idx(rd_addr_c);
    end

    axi4_resp_bytemem #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH)
    ) u_mem (
        .clk     (clk_in_clk),
        .we      (mem_we_c),
        .waddr   (mem_waddr_c),
        .wstrb   (wstrb),
        .wdata   (wdata),
        .raddr   (mem_raddr_c),
        .rdata_c (mem_rdata_c)
    );

    // Write FSM: accept AW, count awlen+1 beats, then hold B until accepted.
    always_ff @(posedge clk_in_clk or negedge reset_n_in_reset_n) begin
        if (!reset_n_in_reset_n) begin
            wstate  <= W_IDLE;
            awready <= 1'b0;
            wready  <= 1'b0;
            bvalid  <= 1'b0;
            bresp   <= RESP_OKAY;
            bid     <= '0;
            waddr_q <= '0;
            wcnt_q  <= '0;
            wlen_q  <= '0;
            werr_q  <= 1'b0;
        end else begin
            case (wstate)
                W_IDLE: begin
                    if (awvalid && awready) begin
                        awready <= 1'b0;
                        wready  <= 1'b1;
                        bid     <= awid;
                        waddr_q <= awaddr;
                        wlen_q  <= awlen;
                        wcnt_q  <= '0;
                        werr_q  <= 1'b0;
                        wstate  <= W_DATA;
                    end else begin
                        awready <= 1'b1;
                    end
                end
                W_DATA: begin
                    if (w_hs_c) begin
                        if (w_final_c) begin
                            wready <= 1'b0;
                            bvalid <= 1'b1;
                            bresp  <= (werr_q || w_beat_err_c) ? RESP_DECERR : RESP_OKAY;
                            wstate <= W_RESP;
                        end else begin
                            wcnt_q  <= wcnt_q + 8'd1;
                            waddr_q <= waddr_q + ADDR_WIDTH'(BYTES);
                            werr_q  <= werr_q || w_beat_err_c;
                        end
                    end
                end
                W_RESP: begin
                    if (bvalid && bready) begin
                        bvalid  <= 1'b0;
                        awready <= 1'b1;
                        wstate  <= W_IDLE;
                    end
                end
                default: begin
                    wstate <= W_IDLE;
                end
            endcase
        end
    end

    // Read FSM: accept AR, present one registered beat at a time, advance on each R handshake.
    always_ff @(posedge clk_in_clk or negedge reset_n_in_reset_n) begin
        if (!reset_n_in_reset_n) begin
            rstate  <= R_IDLE;
            arready <= 1'b0;
            rvalid  <= 1'b0;
            rlast   <= 1'b0;
            rresp   <= RESP_OKAY;
            rid     <= '0;
            rdata   <= '0;
            raddr_q <= '0;
            rcnt_q  <= '0;
            rlen_q  <= '0;
        end else begin
            case (rstate)
                R_IDLE: begin
                    if (arvalid && arready) begin
                        arready <= 1'b0;
                        rvalid  <= 1'b1;
                        rid     <= arid;
                        raddr_q <= araddr;
                        rlen_q  <= arlen;
                        rcnt_q  <= '0;
                        rdata   <= rd_in_range_c ? mem_rdata_c : '0;
                        rresp   <= rd_in_range_c ? RESP_OKAY : RESP_DECERR;
                        rlast   <= (arlen == 8'd0);
                        rstate  <= R_DATA;
                    end else begin
                        arready <= 1'b1;
                    end
                end
                R_DATA: begin
                    if (rvalid && rready) begin
                        if (rlast) begin
                            rvalid  <= 1'b0;
                            rlast   <= 1'b0;
                            arready <= 1'b1;
                            rstate  <= R_IDLE;
                        end else begin
                            raddr_q <= rd_addr_c;
                            rcnt_q  <= rcnt_q + 8'd1;
                            rdata   <= rd_in_range_c ? mem_rdata_c : '0;
                            rresp   <= rd_in_range_c ? RESP_OKAY : RESP_DECERR;
                            rlast   <= ((rcnt_q + 8'd1) == rlen_q);
                        end
                    end
                end
                default: begin
                    rstate <= R_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_axi4_hbm_mem_responder.sv
// Directed bench for the AXI4 memory responder: single beats, bursts, strobes, range edges, concurrency, reset.
module tb_axi4_hbm_mem_responder;

    localparam int unsigned DW    = 256;
    localparam int unsigned AW    = 64;
    localparam int unsigned IW    = 7;
    localparam int unsigned DEPTH = 1024;
    localparam int unsigned BYTES = 32;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [IW-1:0]   awid;
    logic [AW-1:0]   awaddr;
    logic [7:0]      awlen;
    logic            awvalid;
    logic            awready;
    logic [DW-1:0]   wdata;
    logic [BYTES-1:0] wstrb;
    logic            wlast;
    logic            wvalid;
    logic            wready;
    logic [IW-1:0]   bid;
    logic [1:0]      bresp;
    logic            bvalid;
    logic            bready;
    logic [IW-1:0]   arid;
    logic [AW-1:0]   araddr;
    logic [7:0]      arlen;
    logic            arvalid;
    logic            arready;
    logic [IW-1:0]   rid;
    logic [DW-1:0]   rdata;
    logic [1:0]      rresp;
    logic            rlast;
    logic            rvalid;
    logic            rready;

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] wbuf [16];
    logic [DW-1:0] rbuf [16];
    logic [1:0]    rrbuf [16];
    logic          rlbuf [16];
    logic [IW-1:0] ridbuf [16];

    logic [1:0]    w_bresp;
    logic [IW-1:0] w_bid;
    logic          w_tmo;
    logic          w_wready_lat;
    logic          w_bvalid_lat;
    logic          r_tmo;
    logic          r_first_ok;
    int            r_cycles;
    int            r_unstable;

    always #5 clk = ~clk;

    axi4_hbm_mem_responder #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .ID_WIDTH   (IW),
        .DEPTH      (DEPTH),
        .BASE_ADDR  (64'h0)
    ) dut (
        .clk_in_clk         (clk),
        .reset_n_in_reset_n (rst_n),
        .awid    (awid),
        .awaddr  (awaddr),
        .awlen   (awlen),
        .awvalid (awvalid),
        .awready (awready),
        .wdata   (wdata),
        .wstrb   (wstrb),
        .wlast   (wlast),
        .wvalid  (wvalid),
        .wready  (wready),
        .bid     (bid),
        .bresp   (bresp),
        .bvalid  (bvalid),
        .bready  (bready),
        .arid    (arid),
        .araddr  (araddr),
        .arlen   (arlen),
        .arvalid (arvalid),
        .arready (arready),
        .rid     (rid),
        .rdata   (rdata),
        .rresp   (rresp),
        .rlast   (rlast),
        .rvalid  (rvalid),
        .rready  (rready)
    );

    // Drives one write burst from wbuf and captures the B response and handshake latencies.
    task automatic write_burst(input logic [IW-1:0] id, input logic [AW-1:0] addr, input logic [7:0] len,
                               input logic [BYTES-1:0] strb, input bit gaps, input bit bad_last);
        int cyc;
        int i;
        w_tmo = 1'b0;
        @(negedge clk);
        awid = id; awaddr = addr; awlen = len; awvalid = 1'b1;
        cyc = 0;
        while (!awready && cyc < 200) begin @(negedge clk); cyc++; end
        if (!awready) w_tmo = 1'b1;
        @(negedge clk);
        awvalid = 1'b0;
        w_wready_lat = wready;
        i = 0; cyc = 0;
        while (i <= int'(len) && cyc < 500) begin
            if (gaps && $urandom_range(0, 2) == 0) begin
                wvalid = 1'b0;
            end else begin
                wvalid = 1'b1; wdata = wbuf[i]; wstrb = strb;
                wlast = (i == int'(len)) ^ bad_last;
            end
            if (wvalid && wready) i++;
            @(negedge clk); cyc++;
        end
        wvalid = 1'b0; wlast = 1'b0;
        if (i <= int'(len)) w_tmo = 1'b1;
        w_bvalid_lat = bvalid;
        bready = 1'b1; cyc = 0;
        while (!bvalid && cyc < 200) begin @(negedge clk); cyc++; end
        if (!bvalid) w_tmo = 1'b1;
        w_bresp = bresp; w_bid = bid;
        @(negedge clk);
        bready = 1'b0;
    endtask

    // Drives one read burst, records every beat, its spacing and any output change under backpressure.
    task automatic read_burst(input logic [IW-1:0] id, input logic [AW-1:0] addr, input logic [7:0] len, input bit gaps);
        int cyc;
        int beat;
        int first;
        int last;
        bit have;
        logic [DW-1:0] s_d;
        logic [1:0] s_r;
        logic s_l;
        logic [IW-1:0] s_id;
        r_tmo = 1'b0; r_unstable = 0; first = 0; last = 0; have = 1'b0;
        s_d = '0; s_r = '0; s_l = 1'b0; s_id = '0;
        @(negedge clk);
        arid = id; araddr = addr; arlen = len; arvalid = 1'b1;
        cyc = 0;
        while (!arready && cyc < 200) begin @(negedge clk); cyc++; end
        if (!arready) r_tmo = 1'b1;
        @(negedge clk);
        arvalid = 1'b0;
        r_first_ok = rvalid;
        beat = 0; cyc = 0;
        while (beat <= int'(len) && cyc < 500) begin
            if (have && rvalid && (rdata !== s_d || rresp !== s_r || rlast !== s_l || rid !== s_id)) r_unstable++;
            have = 1'b0;
            rready = !(gaps && $urandom_range(0, 2) == 0);
            if (rvalid && rready) begin
                rbuf[beat] = rdata; rrbuf[beat] = rresp; rlbuf[beat] = rlast; ridbuf[beat] = rid;
                if (beat == 0) first = cyc;
                last = cyc;
                beat++;
            end else if (rvalid) begin
                have = 1'b1; s_d = rdata; s_r = rresp; s_l = rlast; s_id = rid;
            end
            @(negedge clk); cyc++;
        end
        rready = 1'b0;
        if (beat <= int'(len)) r_tmo = 1'b1;
        r_cycles = last - first;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks++;
        if ({awready, wready, bvalid, arready, rvalid, rlast} !== 6'b0) begin
            errors++; $display("FAIL reset_ctrl: got %b expected 000000", {awready, wready, bvalid, arready, rvalid, rlast});
        end
        checks++;
        if ({bresp, bid, rresp, rid} !== 18'h0) begin
            errors++; $display("FAIL reset_ids: got %h expected 0", {bresp, bid, rresp, rid});
        end
        checks++;
        if (rdata !== 256'h0) begin
            errors++; $display("FAIL reset_rdata: got %h expected 0", rdata);
        end
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if ({awready, arready} !== 2'b11) begin
            errors++; $display("FAIL ready_after_reset: got %b expected 11", {awready, arready});
        end
    endtask

    task automatic test_single();
        wbuf[0] = {32{8'h01}};
        write_burst(7'h05, 64'h0, 8'd0, {BYTES{1'b1}}, 1'b0, 1'b0);
        checks++;
        if ({w_tmo, w_bresp, w_bid} !== {1'b0, 2'b00, 7'h05}) begin
            errors++; $display("FAIL single_b0: got tmo/resp/id %h expected 005", {w_tmo, w_bresp, w_bid});
        end
        checks++;
        if ({w_wready_lat, w_bvalid_lat} !== 2'b11) begin
            errors++; $display("FAIL write_latency: got %b expected 11", {w_wready_lat, w_bvalid_lat});
        end
        wbuf[0] = {32{8'h02}};
        write_burst(7'h06, 64'h20, 8'd0, {BYTES{1'b1}}, 1'b0, 1'b0);
        checks++;
        if ({w_tmo, w_bresp, w_bid} !== {1'b0, 2'b00, 7'h06}) begin
            errors++; $display("FAIL single_b1: got tmo/resp/id %h expected 006", {w_tmo, w_bresp, w_bid});
        end
        read_burst(7'h11, 64'h0, 8'd0, 1'b0);
        checks++;
        if ({r_tmo, r_first_ok, rbuf[0], rrbuf[0], rlbuf[0], ridbuf[0]} !== {1'b0, 1'b1, {32{8'h01}}, 2'b00, 1'b1, 7'h11}) begin
            errors++; $display("FAIL single_r0: got data %h resp %b last %b id %h", rbuf[0], rrbuf[0], rlbuf[0], ridbuf[0]);
        end
        read_burst(7'h12, 64'h20, 8'd0, 1'b0);
        checks++;
        if ({r_tmo, r_first_ok, rbuf[0], rrbuf[0], rlbuf[0], ridbuf[0]} !== {1'b0, 1'b1, {32{8'h02}}, 2'b00, 1'b1, 7'h12}) begin
            errors++; $display("FAIL single_r1: got data %h resp %b last %b id %h", rbuf[0], rrbuf[0], rlbuf[0], ridbuf[0]);
        end
    endtask

    task automatic test_burst8();
        for (int i = 0; i < 8; i++) wbuf[i] = DW'(i);
        write_burst(7'h01, 64'h0, 8'd7, {BYTES{1'b1}}, 1'b0, 1'b0);
        checks++;
        if ({w_tmo, w_bresp} !== 3'b000) begin
            errors++; $display("FAIL burst_b: got %b expected 000", {w_tmo, w_bresp});
        end
        read_burst(7'h02, 64'h0, 8'd7, 1'b0);
        checks++;
        if ({r_tmo, r_first_ok} !== 2'b01 || r_cycles != 7) begin
            errors++; $display("FAIL burst_spacing: got tmo %b first %b span %0d expected 0 1 7", r_tmo, r_first_ok, r_cycles);
        end
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (rbuf[i] !== DW'(i) || rrbuf[i] !== 2'b00 || rlbuf[i] !== (i == 7)) begin
                errors++; $display("FAIL burst_beat%0d: got data %h resp %b last %b", i, rbuf[i], rrbuf[i], rlbuf[i]);
            end
        end
    endtask

    task automatic test_strobe();
        wbuf[0] = {32{8'hFF}};
        write_burst(7'h03, 64'h400, 8'd0, {BYTES{1'b1}}, 1'b0, 1'b0);
        wbuf[0] = {32{8'hA5}};
        write_burst(7'h03, 64'h400, 8'd0, 32'h0000_000F, 1'b0, 1'b0);
        read_burst(7'h04, 64'h400, 8'd0, 1'b0);
        checks++;
        if (rbuf[0] !== {{28{8'hFF}}, {4{8'hA5}}}) begin
            errors++; $display("FAIL strobe: got %h expected %h", rbuf[0], {{28{8'hFF}}, {4{8'hA5}}});
        end
    endtask

    task automatic test_range();
        wbuf[0] = {32{8'h3C}};
        write_burst(7'h07, 64'h7FE0, 8'd0, {BYTES{1'b1}}, 1'b0, 1'b0);
        checks++;
        if (w_bresp !== 2'b00) begin
            errors++; $display("FAIL top_word_write: got %b expected 00", w_bresp);
        end
        read_burst(7'h08, 64'h7FE0, 8'd1, 1'b0);
        checks++;
        if ({rbuf[0], rrbuf[0], rlbuf[0]} !== {{32{8'h3C}}, 2'b00, 1'b0}) begin
            errors++; $display("FAIL range_beat0: got data %h resp %b last %b", rbuf[0], rrbuf[0], rlbuf[0]);
        end
        checks++;
        if ({r_tmo, rbuf[1], rrbuf[1], rlbuf[1]} !== {1'b0, 256'h0, 2'b11, 1'b1}) begin
            errors++; $display("FAIL range_beat1: got data %h resp %b last %b expected 0 11 1", rbuf[1], rrbuf[1], rlbuf[1]);
        end
        wbuf[0] = {32{8'h99}};
        write_burst(7'h09, 64'h8000, 8'd0, {BYTES{1'b1}}, 1'b0, 1'b0);
        checks++;
        if (w_bresp !== 2'b11) begin
            errors++; $display("FAIL oob_write_resp: got %b expected 11", w_bresp);
        end
        read_burst(7'h0A, 64'h0, 8'd0, 1'b0);
        checks++;
        if (rbuf[0] !== 256'h0) begin
            errors++; $display("FAIL oob_no_alias: got %h expected 0", rbuf[0]);
        end
        wbuf[0] = {32{8'h77}};
        wbuf[1] = {32{8'h99}};
        write_burst(7'h0B, 64'h7FE0, 8'd1, {BYTES{1'b1}}, 1'b0, 1'b0);
        checks++;
        if (w_bresp !== 2'b11) begin
            errors++; $display("FAIL straddle_resp: got %b expected 11", w_bresp);
        end
        read_burst(7'h0C, 64'h7FE0, 8'd0, 1'b0);
        checks++;
        if (rbuf[0] !== {32{8'h77}}) begin
            errors++; $display("FAIL straddle_data: got %h expected %h", rbuf[0], {32{8'h77}});
        end
        write_burst(7'h0D, 64'h200, 8'd1, {BYTES{1'b1}}, 1'b0, 1'b1);
        checks++;
        if ({w_tmo, w_bresp} !== 3'b011) begin
            errors++; $display("FAIL wlast_mismatch: got %b expected 011", {w_tmo, w_bresp});
        end
    endtask

    task automatic test_concurrent();
        for (int i = 0; i < 8; i++) wbuf[i] = 256'hC0DE_0000 + DW'(i);
        fork
            write_burst(7'h2A, 64'h1000, 8'd7, {BYTES{1'b1}}, 1'b1, 1'b0);
            read_burst(7'h15, 64'h0, 8'd7, 1'b1);
        join
        checks++;
        if ({w_tmo, w_bresp, w_bid} !== {1'b0, 2'b00, 7'h2A}) begin
            errors++; $display("FAIL conc_b: got %h expected 02a", {w_tmo, w_bresp, w_bid});
        end
        checks++;
        if (r_tmo !== 1'b0 || r_unstable != 0) begin
            errors++; $display("FAIL conc_stable: got tmo %b unstable %0d expected 0 0", r_tmo, r_unstable);
        end
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (rbuf[i] !== DW'(i) || rrbuf[i] !== 2'b00 || rlbuf[i] !== (i == 7) || ridbuf[i] !== 7'h15) begin
                errors++; $display("FAIL conc_rbeat%0d: got data %h resp %b last %b id %h", i, rbuf[i], rrbuf[i], rlbuf[i], ridbuf[i]);
            end
        end
        read_burst(7'h16, 64'h1000, 8'd7, 1'b1);
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (rbuf[i] !== 256'hC0DE_0000 + DW'(i)) begin
                errors++; $display("FAIL conc_wbeat%0d: got %h expected %h", i, rbuf[i], 256'hC0DE_0000 + DW'(i));
            end
        end
    endtask

    task automatic test_reset_midburst();
        int cyc;
        @(negedge clk);
        awid = 7'h03; awaddr = 64'h2000; awlen = 8'd7; awvalid = 1'b1;
        cyc = 0;
        while (!awready && cyc < 200) begin @(negedge clk); cyc++; end
        @(negedge clk);
        awvalid = 1'b0;
        checks++;
        if (wready !== 1'b1) begin
            errors++; $display("FAIL mid_wready: got %b expected 1", wready);
        end
        for (int i = 0; i < 3; i++) begin
            wvalid = 1'b1; wdata = 256'h00BE_EF00 + DW'(i); wstrb = {BYTES{1'b1}}; wlast = 1'b0;
            @(negedge clk);
        end
        wdata = 256'h00BE_EF03;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({awready, wready, bvalid, arready, rvalid} !== 5'b0) begin
            errors++; $display("FAIL mid_reset_async: got %b expected 00000", {awready, wready, bvalid, arready, rvalid});
        end
        @(negedge clk);
        checks++;
        if ({awready, wready, bvalid, arready, rvalid} !== 5'b0) begin
            errors++; $display("FAIL mid_reset_edge: got %b expected 00000", {awready, wready, bvalid, arready, rvalid});
        end
        wvalid = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if ({awready, wready, arready} !== 3'b101) begin
            errors++; $display("FAIL mid_release: got %b expected 101", {awready, wready, arready});
        end
        wbuf[0] = {32{8'h5A}};
        wbuf[1] = {32{8'h6B}};
        write_burst(7'h0E, 64'h3000, 8'd1, {BYTES{1'b1}}, 1'b0, 1'b0);
        checks++;
        if ({w_tmo, w_bresp, w_bid} !== {1'b0, 2'b00, 7'h0E}) begin
            errors++; $display("FAIL fresh_b: got %h expected 00e", {w_tmo, w_bresp, w_bid});
        end
        read_burst(7'h0F, 64'h3000, 8'd1, 1'b0);
        checks++;
        if ({rbuf[0], rbuf[1]} !== {{32{8'h5A}}, {32{8'h6B}}}) begin
            errors++; $display("FAIL fresh_data: got %h %h", rbuf[0], rbuf[1]);
        end
        read_burst(7'h10, 64'h2000, 8'd2, 1'b0);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (rbuf[i] !== 256'h00BE_EF00 + DW'(i)) begin
                errors++; $display("FAIL partial_beat%0d: got %h expected %h", i, rbuf[i], 256'h00BE_EF00 + DW'(i));
            end
        end
    endtask

    initial begin
        awid = '0; awaddr = '0; awlen = '0; awvalid = 1'b0;
        wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0; bready = 1'b0;
        arid = '0; araddr = '0; arlen = '0; arvalid = 1'b0; rready = 1'b0;
        test_reset();
        test_single();
        test_burst8();
        test_strobe();
        test_range();
        test_concurrent();
        test_reset_midburst();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
